sram_line_controller: RTL and testbench

- Sits directly downstream of the fill/alpha SRAM request multiplexer.
- Accepts one 1536-bit line request: 64 pixels x 24-bit RGB, one read or write per request.
- Serialises a write into NUM_BEATS 32-bit accesses to the physical SRAM port.
- Gathers a read's NUM_BEATS 32-bit words back into one line and signals completion with a one-cycle done pulse.

---
 rtl/sram_line_controller.sv | 124 ++++++++++++
 tb/tb_sram_line_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_line_controller.sv
// Line-wide SRAM front end: splits a 1536-bit line request into
// single-word SRAM beats and gathers read words back into a line.
module sram_line_controller #(
  parameter int DATA_W    = 32,
  parameter int NUM_BEATS = 48,
  parameter int ADDR_W    = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read_enable,
  input  logic                        write_enable,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W*NUM_BEATS-1:0] write_data,
  output logic                        busy,
  output logic                        done,
  output logic                        req_conflict,
  output logic [DATA_W*NUM_BEATS-1:0] read_data,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LINE_W = DATA_W * NUM_BEATS;
  localparam int CNT_W  = $clog2(NUM_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  beat;
  logic [CNT_W-1:0]  slot;
  logic [ADDR_W-1:0] cur_addr;
  logic [LINE_W-1:0] line;
  logic              rd_pend;
  logic              last;

  assign last = (beat == CNT_W'(NUM_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (write_enable)     state_nx = WRITE;
        else if (read_enable) state_nx = READ;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = line[DATA_W-1:0];
        if (last) state_nx = DONE;
      end
      READ: begin
        mem_re   = 1'b1;
        mem_addr = cur_addr;
        if (last) state_nx = READ_WAIT;
      end
      READ_WAIT: state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write data shifts down one word per beat so the SRAM word is
  // always the low slice; read words land in the slot of their strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat         <= '0;
      slot         <= '0;
      cur_addr     <= '0;
      line         <= '0;
      rd_pend      <= 1'b0;
      read_data    <= '0;
      req_conflict <= 1'b0;
    end else begin
      req_conflict <= 1'b0;
      rd_pend      <= (state == READ);
      slot         <= beat;
      if (rd_pend)
        read_data[slot*DATA_W +: DATA_W] <= mem_rdata;
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (write_enable || read_enable) cur_addr <= address;
          if (write_enable) line <= write_data;
          req_conflict <= write_enable & read_enable;
        end
        WRITE: begin
          beat     <= last ? '0 : beat + 1'b1;
          cur_addr <= cur_addr + 1'b1;
          line     <= line >> DATA_W;
        end
        READ: begin
          beat     <= last ? '0 : beat + 1'b1;
          cur_addr <= cur_addr + 1'b1;
        end
        default: beat <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_controller.sv
// Directed bench for sram_line_controller: write, read, wrap,
// conflict, dropped request and asynchronous reset scenarios.
module tb_sram_line_controller;

  logic          clk;
  logic          rst;
  logic          read_enable;
  logic          write_enable;
  logic [23:0]   address;
  logic [1535:0] write_data;
  logic          busy;
  logic          done;
  logic          req_conflict;
  logic [1535:0] read_data;
  logic          mem_re;
  logic          mem_we;
  logic [23:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int re_cnt   = 0;

  sram_line_controller dut (
    .clk(clk),
    .rst(rst),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .write_data(write_data),
    .busy(busy),
    .done(done),
    .req_conflict(req_conflict),
    .read_data(read_data),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word k of a line at 0x000100 reads back as 0xA0000000+k
  always @(posedge clk) begin
    mem_rdata <= {24'hA00000, mem_addr[7:0]};
    if (done)   done_cnt = done_cnt + 1;
    if (mem_re) re_cnt   = re_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write_seq(input logic [23:0] addr,
                              input logic [1535:0] ln,
                              input bit conflict,
                              input int rd_at);
    int d0;
    int r0;
    logic [23:0] ea;
    d0 = done_cnt;
    r0 = re_cnt;
    address      = addr;
    write_data   = ln;
    write_enable = 1'b1;
    read_enable  = conflict;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    for (int b = 0; b < 48; b++) begin
      ea = addr + 24'(b);
      total++;
      if (mem_we !== 1'b1) begin
        bad++;
        $display("FAIL wr_we beat=%0d got=%b exp=1", b, mem_we);
      end
      total++;
      if (mem_addr !== ea) begin
        bad++;
        $display("FAIL wr_addr beat=%0d got=%h exp=%h", b, mem_addr, ea);
      end
      total++;
      if (mem_wdata !== ln[32*b +: 32]) begin
        bad++;
        $display("FAIL wr_data beat=%0d got=%h exp=%h",
                 b, mem_wdata, ln[32*b +: 32]);
      end
      total++;
      if (busy !== 1'b1 || mem_re !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL wr_ctrl beat=%0d got busy=%b re=%b done=%b exp 1/0/0",
                 b, busy, mem_re, done);
      end
      total++;
      if (req_conflict !== (conflict && b == 0)) begin
        bad++;
        $display("FAIL wr_conflict beat=%0d got=%b exp=%b",
                 b, req_conflict, conflict && b == 0);
      end
      if (b == rd_at) read_enable = 1'b1;
      step();
      read_enable = 1'b0;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 ||
        mem_addr !== 24'h0) begin
      bad++;
      $display("FAIL wr_done got done=%b busy=%b we=%b addr=%h exp 1/1/0/0",
               done, busy, mem_we, mem_addr);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_idle got done=%b busy=%b exp 0/0", done, busy);
    end
    repeat (3) step();
    total++;
    if (done_cnt - d0 != 1 || re_cnt - r0 != 0) begin
      bad++;
      $display("FAIL wr_counts got done=%0d re=%0d exp 1/0",
               done_cnt - d0, re_cnt - r0);
    end
  endtask

  function automatic logic [1535:0] mk_line(input logic [31:0] off);
    logic [1535:0] l;
    for (int k = 0; k < 48; k++) l[32*k +: 32] = off + 32'(k);
    return l;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({busy, done, req_conflict, mem_re, mem_we} !== 5'b0 ||
        mem_addr !== 24'h0 || mem_wdata !== 32'h0 || read_data !== '0) begin
      bad++;
      $display("FAIL reset got busy=%b done=%b rc=%b re=%b we=%b a=%h wd=%h",
               busy, done, req_conflict, mem_re, mem_we, mem_addr, mem_wdata);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    do_write_seq(24'h000100, mk_line(32'h0), 1'b0, -1);
  endtask

  task automatic test_read();
    int d0;
    d0 = done_cnt;
    address     = 24'h000100;
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    for (int b = 0; b < 48; b++) begin
      total++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 ||
          mem_addr !== 24'h000100 + 24'(b)) begin
        bad++;
        $display("FAIL rd_beat beat=%0d got re=%b we=%b busy=%b a=%h exp 1/0/1/%h",
                 b, mem_re, mem_we, busy, mem_addr, 24'h000100 + 24'(b));
      end
      step();
    end
    total++;
    if (mem_re !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rd_wait got re=%b done=%b busy=%b exp 0/0/1",
               mem_re, done, busy);
    end
    step();
    total++;
    if (done !== 1'b1 || mem_addr !== 24'h0) begin
      bad++;
      $display("FAIL rd_done got done=%b addr=%h exp 1/0", done, mem_addr);
    end
    for (int k = 0; k < 48; k++) begin
      total++;
      if (read_data[32*k +: 32] !== 32'hA0000000 + 32'(k)) begin
        bad++;
        $display("FAIL rd_data word=%0d got=%h exp=%h",
                 k, read_data[32*k +: 32], 32'hA0000000 + 32'(k));
      end
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL rd_end got done=%b busy=%b pulses=%0d exp 0/0/1",
               done, busy, done_cnt - d0);
    end
    total++;
    if (read_data[32*47 +: 32] !== 32'hA000002F) begin
      bad++;
      $display("FAIL rd_hold got=%h exp=a000002f", read_data[32*47 +: 32]);
    end
  endtask

  task automatic test_wrap();
    do_write_seq(24'hFFFFF0, mk_line(32'h55000000), 1'b0, -1);
  endtask

  task automatic test_conflict();
    do_write_seq(24'h000400, ~mk_line(32'h0), 1'b1, -1);
  endtask

  task automatic test_busy_drop();
    do_write_seq(24'h000800, mk_line(32'h12340000), 1'b0, 10);
  endtask

  task automatic test_reset_mid();
    int d0;
    address     = 24'h000200;
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    repeat (20) step();
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 24'h000214) begin
      bad++;
      $display("FAIL rst_pre got re=%b a=%h exp 1/000214", mem_re, mem_addr);
    end
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_re !== 1'b0 || busy !== 1'b0 || mem_addr !== 24'h0 ||
        read_data !== '0) begin
      bad++;
      $display("FAIL rst_async got re=%b busy=%b a=%h exp 0/0/0",
               mem_re, busy, mem_addr);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    total++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_nodone got pulses=%0d busy=%b exp 0/0",
               done_cnt - d0, busy);
    end
    do_write_seq(24'h000100, mk_line(32'h0), 1'b0, -1);
  endtask

  initial begin
    rst          = 1'b1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_conflict();
    test_busy_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
